// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 key schedule.
package aes_pkg;

   // Number of rounds for AES-128; round keys rk0..rk10.
   localparam int NR = 10;

   // Round constants for rounds 1..10 (the leading byte of Rcon[i]).
   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef logic [31:0] word_t;

   // Controller states. EMIT0 publishes the raw cipher key, SUB walks the
   // four SubWord bytes through the shared S-box, XFORM folds them in.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT0 = 2'd1,
      SUB   = 2'd2,
      XFORM = 2'd3
   } state_e;

   // Round constant lookup; indices outside 1..NR return 0.
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      rcon_of = 8'h00;
      for (int i = 1; i <= NR; i++) begin
         if (r == 4'(i)) rcon_of = RCON[i];
      end
   endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Byte-wide combinational forward AES S-box, one lookup per cycle.
module aes_sbox_byte (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Full 256-entry substitution table.
   always_comb begin
      out_o = 8'h00;
      case (in_i)
         8'h00: out_o = 8'h63; 8'h01: out_o = 8'h7c; 8'h02: out_o = 8'h77; 8'h03: out_o = 8'h7b; 8'h04: out_o = 8'hf2; 8'h05: out_o = 8'h6b; 8'h06: out_o = 8'h6f; 8'h07: out_o = 8'hc5;
         8'h08: out_o = 8'h30; 8'h09: out_o = 8'h01; 8'h0a: out_o = 8'h67; 8'h0b: out_o = 8'h2b; 8'h0c: out_o = 8'hfe; 8'h0d: out_o = 8'hd7; 8'h0e: out_o = 8'hab; 8'h0f: out_o = 8'h76;
         8'h10: out_o = 8'hca; 8'h11: out_o = 8'h82; 8'h12: out_o = 8'hc9; 8'h13: out_o = 8'h7d; 8'h14: out_o = 8'hfa; 8'h15: out_o = 8'h59; 8'h16: out_o = 8'h47; 8'h17: out_o = 8'hf0;
         8'h18: out_o = 8'had; 8'h19: out_o = 8'hd4; 8'h1a: out_o = 8'ha2; 8'h1b: out_o = 8'haf; 8'h1c: out_o = 8'h9c; 8'h1d: out_o = 8'ha4; 8'h1e: out_o = 8'h72; 8'h1f: out_o = 8'hc0;
         8'h20: out_o = 8'hb7; 8'h21: out_o = 8'hfd; 8'h22: out_o = 8'h93; 8'h23: out_o = 8'h26; 8'h24: out_o = 8'h36; 8'h25: out_o = 8'h3f; 8'h26: out_o = 8'hf7; 8'h27: out_o = 8'hcc;
         8'h28: out_o = 8'h34; 8'h29: out_o = 8'ha5; 8'h2a: out_o = 8'he5; 8'h2b: out_o = 8'hf1; 8'h2c: out_o = 8'h71; 8'h2d: out_o = 8'hd8; 8'h2e: out_o = 8'h31; 8'h2f: out_o = 8'h15;
         8'h30: out_o = 8'h04; 8'h31: out_o = 8'hc7; 8'h32: out_o = 8'h23; 8'h33: out_o = 8'hc3; 8'h34: out_o = 8'h18; 8'h35: out_o = 8'h96; 8'h36: out_o = 8'h05; 8'h37: out_o = 8'h9a;
         8'h38: out_o = 8'h07; 8'h39: out_o = 8'h12; 8'h3a: out_o = 8'h80; 8'h3b: out_o = 8'he2; 8'h3c: out_o = 8'heb; 8'h3d: out_o = 8'h27; 8'h3e: out_o = 8'hb2; 8'h3f: out_o = 8'h75;
         8'h40: out_o = 8'h09; 8'h41: out_o = 8'h83; 8'h42: out_o = 8'h2c; 8'h43: out_o = 8'h1a; 8'h44: out_o = 8'h1b; 8'h45: out_o = 8'h6e; 8'h46: out_o = 8'h5a; 8'h47: out_o = 8'ha0;
         8'h48: out_o = 8'h52; 8'h49: out_o = 8'h3b; 8'h4a: out_o = 8'hd6; 8'h4b: out_o = 8'hb3; 8'h4c: out_o = 8'h29; 8'h4d: out_o = 8'he3; 8'h4e: out_o = 8'h2f; 8'h4f: out_o = 8'h84;
         8'h50: out_o = 8'h53; 8'h51: out_o = 8'hd1; 8'h52: out_o = 8'h00; 8'h53: out_o = 8'hed; 8'h54: out_o = 8'h20; 8'h55: out_o = 8'hfc; 8'h56: out_o = 8'hb1; 8'h57: out_o = 8'h5b;
         8'h58: out_o = 8'h6a; 8'h59: out_o = 8'hcb; 8'h5a: out_o = 8'hbe; 8'h5b: out_o = 8'h39; 8'h5c: out_o = 8'h4a; 8'h5d: out_o = 8'h4c; 8'h5e: out_o = 8'h58; 8'h5f: out_o = 8'hcf;
         8'h60: out_o = 8'hd0; 8'h61: out_o = 8'hef; 8'h62: out_o = 8'haa; 8'h63: out_o = 8'hfb; 8'h64: out_o = 8'h43; 8'h65: out_o = 8'h4d; 8'h66: out_o = 8'h33; 8'h67: out_o = 8'h85;
         8'h68: out_o = 8'h45; 8'h69: out_o = 8'hf9; 8'h6a: out_o = 8'h02; 8'h6b: out_o = 8'h7f; 8'h6c: out_o = 8'h50; 8'h6d: out_o = 8'h3c; 8'h6e: out_o = 8'h9f; 8'h6f: out_o = 8'ha8;
         8'h70: out_o = 8'h51; 8'h71: out_o = 8'ha3; 8'h72: out_o = 8'h40; 8'h73: out_o = 8'h8f; 8'h74: out_o = 8'h92; 8'h75: out_o = 8'h9d; 8'h76: out_o = 8'h38; 8'h77: out_o = 8'hf5;
         8'h78: out_o = 8'hbc; 8'h79: out_o = 8'hb6; 8'h7a: out_o = 8'hda; 8'h7b: out_o = 8'h21; 8'h7c: out_o = 8'h10; 8'h7d: out_o = 8'hff; 8'h7e: out_o = 8'hf3; 8'h7f: out_o = 8'hd2;
         8'h80: out_o = 8'hcd; 8'h81: out_o = 8'h0c; 8'h82: out_o = 8'h13; 8'h83: out_o = 8'hec; 8'h84: out_o = 8'h5f; 8'h85: out_o = 8'h97; 8'h86: out_o = 8'h44; 8'h87: out_o = 8'h17;
         8'h88: out_o = 8'hc4; 8'h89: out_o = 8'ha7; 8'h8a: out_o = 8'h7e; 8'h8b: out_o = 8'h3d; 8'h8c: out_o = 8'h64; 8'h8d: out_o = 8'h5d; 8'h8e: out_o = 8'h19; 8'h8f: out_o = 8'h73;
         8'h90: out_o = 8'h60; 8'h91: out_o = 8'h81; 8'h92: out_o = 8'h4f; 8'h93: out_o = 8'hdc; 8'h94: out_o = 8'h22; 8'h95: out_o = 8'h2a; 8'h96: out_o = 8'h90; 8'h97: out_o = 8'h88;
         8'h98: out_o = 8'h46; 8'h99: out_o = 8'hee; 8'h9a: out_o = 8'hb8; 8'h9b: out_o = 8'h14; 8'h9c: out_o = 8'hde; 8'h9d: out_o = 8'h5e; 8'h9e: out_o = 8'h0b; 8'h9f: out_o = 8'hdb;
         8'ha0: out_o = 8'he0; 8'ha1: out_o = 8'h32; 8'ha2: out_o = 8'h3a; 8'ha3: out_o = 8'h0a; 8'ha4: out_o = 8'h49; 8'ha5: out_o = 8'h06; 8'ha6: out_o = 8'h24; 8'ha7: out_o = 8'h5c;
         8'ha8: out_o = 8'hc2; 8'ha9: out_o = 8'hd3; 8'haa: out_o = 8'hac; 8'hab: out_o = 8'h62; 8'hac: out_o = 8'h91; 8'had: out_o = 8'h95; 8'hae: out_o = 8'he4; 8'haf: out_o = 8'h79;
         8'hb0: out_o = 8'he7; 8'hb1: out_o = 8'hc8; 8'hb2: out_o = 8'h37; 8'hb3: out_o = 8'h6d; 8'hb4: out_o = 8'h8d; 8'hb5: out_o = 8'hd5; 8'hb6: out_o = 8'h4e; 8'hb7: out_o = 8'ha9;
         8'hb8: out_o = 8'h6c; 8'hb9: out_o = 8'h56; 8'hba: out_o = 8'hf4; 8'hbb: out_o = 8'hea; 8'hbc: out_o = 8'h65; 8'hbd: out_o = 8'h7a; 8'hbe: out_o = 8'hae; 8'hbf: out_o = 8'h08;
         8'hc0: out_o = 8'hba; 8'hc1: out_o = 8'h78; 8'hc2: out_o = 8'h25; 8'hc3: out_o = 8'h2e; 8'hc4: out_o = 8'h1c; 8'hc5: out_o = 8'ha6; 8'hc6: out_o = 8'hb4; 8'hc7: out_o = 8'hc6;
         8'hc8: out_o = 8'he8; 8'hc9: out_o = 8'hdd; 8'hca: out_o = 8'h74; 8'hcb: out_o = 8'h1f; 8'hcc: out_o = 8'h4b; 8'hcd: out_o = 8'hbd; 8'hce: out_o = 8'h8b; 8'hcf: out_o = 8'h8a;
         8'hd0: out_o = 8'h70; 8'hd1: out_o = 8'h3e; 8'hd2: out_o = 8'hb5; 8'hd3: out_o = 8'h66; 8'hd4: out_o = 8'h48; 8'hd5: out_o = 8'h03; 8'hd6: out_o = 8'hf6; 8'hd7: out_o = 8'h0e;
         8'hd8: out_o = 8'h61; 8'hd9: out_o = 8'h35; 8'hda: out_o = 8'h57; 8'hdb: out_o = 8'hb9; 8'hdc: out_o = 8'h86; 8'hdd: out_o = 8'hc1; 8'hde: out_o = 8'h1d; 8'hdf: out_o = 8'h9e;
         8'he0: out_o = 8'he1; 8'he1: out_o = 8'hf8; 8'he2: out_o = 8'h98; 8'he3: out_o = 8'h11; 8'he4: out_o = 8'h69; 8'he5: out_o = 8'hd9; 8'he6: out_o = 8'h8e; 8'he7: out_o = 8'h94;
         8'he8: out_o = 8'h9b; 8'he9: out_o = 8'h1e; 8'hea: out_o = 8'h87; 8'heb: out_o = 8'he9; 8'hec: out_o = 8'hce; 8'hed: out_o = 8'h55; 8'hee: out_o = 8'h28; 8'hef: out_o = 8'hdf;
         8'hf0: out_o = 8'h8c; 8'hf1: out_o = 8'ha1; 8'hf2: out_o = 8'h89; 8'hf3: out_o = 8'h0d; 8'hf4: out_o = 8'hbf; 8'hf5: out_o = 8'he6; 8'hf6: out_o = 8'h42; 8'hf7: out_o = 8'h68;
         8'hf8: out_o = 8'h41; 8'hf9: out_o = 8'h99; 8'hfa: out_o = 8'h2d; 8'hfb: out_o = 8'h0f; 8'hfc: out_o = 8'hb0; 8'hfd: out_o = 8'h54; 8'hfe: out_o = 8'hbb; 8'hff: out_o = 8'h16;
      endcase
   end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion. One byte-wide S-box is time-shared
// across the four SubWord bytes, so each round takes four SUB cycles plus
// one XFORM cycle. rk0 appears one cycle after start, rk_n at 1+5n.
//
// Output handshake: rk_valid is a one-cycle strobe with no ready/back-
// pressure; rk and rk_idx are only meaningful in the cycle rk_valid is
// high and otherwise hold the last published key. done strobes together
// with the rk_valid of rk10.
module aes_key_sched
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_idx,
   output logic [127:0] rk,
   output logic         done
);

   state_e       state_q;
   word_t        w_q [0:3];
   word_t        tmp_q;
   logic [3:0]   round_q;
   logic [1:0]   bc_q;
   logic         busy_q;
   logic         rk_valid_q;
   logic [3:0]   rk_idx_q;
   logic [127:0] rk_q;
   logic         done_q;

   logic [7:0]   sbox_in;
   logic [7:0]   sbox_out;
   logic [3:0]   round_d;
   word_t        t_d;
   word_t        w0_d;
   word_t        w1_d;
   word_t        w2_d;
   word_t        w3_d;

   aes_sbox_byte u_sbox (
      .in_i  (sbox_in),
      .out_o (sbox_out)
   );

   // S-box operand is byte bc of RotWord(w3): w3 bytes 1, 2, 3, 0.
   // Next-round words chain through 32-bit XORs off the finished tmp.
   always_comb begin
      sbox_in = 8'h00;
      case (bc_q)
         2'd0: sbox_in = w_q[3][23:16];
         2'd1: sbox_in = w_q[3][15:8];
         2'd2: sbox_in = w_q[3][7:0];
         2'd3: sbox_in = w_q[3][31:24];
         default: sbox_in = 8'h00;
      endcase
      round_d = round_q + 4'd1;
      t_d     = tmp_q ^ {rcon_of(round_d), 24'h000000};
      w0_d    = w_q[0] ^ t_d;
      w1_d    = w_q[1] ^ w0_d;
      w2_d    = w_q[2] ^ w1_d;
      w3_d    = w_q[3] ^ w2_d;
   end

   // Controller FSM with registered outputs; strobes default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         tmp_q      <= '0;
         round_q    <= '0;
         bc_q       <= '0;
         busy_q     <= 1'b0;
         rk_valid_q <= 1'b0;
         rk_idx_q   <= '0;
         rk_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         rk_valid_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (start) begin
                  w_q[0]  <= key[127:96];
                  w_q[1]  <= key[95:64];
                  w_q[2]  <= key[63:32];
                  w_q[3]  <= key[31:0];
                  round_q <= '0;
                  bc_q    <= '0;
                  state_q <= EMIT0;
               end
            end
            EMIT0: begin
               busy_q     <= 1'b1;
               rk_q       <= {w_q[0], w_q[1], w_q[2], w_q[3]};
               rk_idx_q   <= 4'd0;
               rk_valid_q <= 1'b1;
               state_q    <= SUB;
            end
            SUB: begin
               case (bc_q)
                  2'd0: tmp_q[31:24] <= sbox_out;
                  2'd1: tmp_q[23:16] <= sbox_out;
                  2'd2: tmp_q[15:8]  <= sbox_out;
                  2'd3: tmp_q[7:0]   <= sbox_out;
                  default: tmp_q     <= tmp_q;
               endcase
               bc_q <= bc_q + 2'd1;
               if (bc_q == 2'd3) state_q <= XFORM;
            end
            XFORM: begin
               round_q    <= round_d;
               w_q[0]     <= w0_d;
               w_q[1]     <= w1_d;
               w_q[2]     <= w2_d;
               w_q[3]     <= w3_d;
               rk_q       <= {w0_d, w1_d, w2_d, w3_d};
               rk_idx_q   <= round_d;
               rk_valid_q <= 1'b1;
               if (round_d == 4'(NR)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  state_q <= SUB;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_idx   = rk_idx_q;
   assign rk       = rk_q;
   assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched: FIPS-197 A.1 and all-zero key vectors,
// ignored restarts, asynchronous abort and continuous start.
module tb_aes_key_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk;
   logic         done;

   int checks = 0;
   int failures = 0;

   logic [127:0] a1_key;
   logic [127:0] a1_rk [0:10];
   logic [127:0] zero_rk1;
   logic [127:0] zero_rk10;

   aes_key_sched dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_idx   (rk_idx),
      .rk       (rk),
      .done     (done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      key   = '0;
      #1;
      checks++;
      if ({busy, rk_valid, rk_idx, rk, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b v=%b idx=%0d rk=%h done=%b exp all 0", busy, rk_valid, rk_idx, rk, done);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, rk_valid, rk_idx, rk, done} !== '0) begin
         failures++;
         $display("FAIL reset_hold got busy=%b v=%b idx=%0d rk=%h done=%b exp all 0", busy, rk_valid, rk_idx, rk, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fips_a1();
      int pulses;
      logic exp_v;
      int n;
      pulses = 0;
      @(negedge clk);
      key   = a1_key;
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL a1_busy_c0 got=%b exp=0", busy);
      end
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         start = 1'b0;
         key   = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         exp_v = ((k - 1) % 5 == 0);
         n     = (k - 1) / 5;
         if (rk_valid === 1'b1) pulses++;
         checks++;
         if (rk_valid !== exp_v) begin
            failures++;
            $display("FAIL a1_valid c=%0d got=%b exp=%b", k, rk_valid, exp_v);
         end
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL a1_busy c=%0d got=%b exp=1", k, busy);
         end
         checks++;
         if (done !== (k == 51)) begin
            failures++;
            $display("FAIL a1_done c=%0d got=%b exp=%b", k, done, (k == 51));
         end
         if (exp_v) begin
            checks++;
            if (rk_idx !== 4'(n)) begin
               failures++;
               $display("FAIL a1_idx c=%0d got=%0d exp=%0d", k, rk_idx, n);
            end
            checks++;
            if (rk !== a1_rk[n]) begin
               failures++;
               $display("FAIL a1_rk c=%0d got=%h exp=%h", k, rk, a1_rk[n]);
            end
         end
      end
      checks++;
      if (pulses != 11) begin
         failures++;
         $display("FAIL a1_pulse_count got=%0d exp=11", pulses);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({busy, rk_valid, done} !== 3'b000 || rk !== a1_rk[10]) begin
         failures++;
         $display("FAIL a1_after got busy=%b v=%b done=%b rk=%h exp 0 0 0 rk=%h", busy, rk_valid, done, rk, a1_rk[10]);
      end
   endtask

   task automatic test_zero_key();
      @(negedge clk);
      key   = '0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
         #1;
         if (k == 6) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'd1 || rk !== zero_rk1) begin
               failures++;
               $display("FAIL zero_rk1 got v=%b idx=%0d rk=%h exp v=1 idx=1 rk=%h", rk_valid, rk_idx, rk, zero_rk1);
            end
         end
         if (k == 51) begin
            checks++;
            if (rk_valid !== 1'b1 || done !== 1'b1 || rk_idx !== 4'd10 || rk !== zero_rk10) begin
               failures++;
               $display("FAIL zero_rk10 got v=%b done=%b idx=%0d rk=%h exp v=1 done=1 idx=10 rk=%h", rk_valid, done, rk_idx, rk, zero_rk10);
            end
         end
      end
      @(posedge clk);
   endtask

   task automatic test_ignore_start();
      logic exp_v;
      int n;
      @(negedge clk);
      key   = a1_key;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         start = (k == 10 || k == 30);
         key   = ~a1_key;
         @(posedge clk);
         #1;
         exp_v = ((k - 1) % 5 == 0);
         n     = (k - 1) / 5;
         checks++;
         if (rk_valid !== exp_v || done !== (k == 51)) begin
            failures++;
            $display("FAIL ign_strobe c=%0d got v=%b done=%b exp v=%b done=%b", k, rk_valid, done, exp_v, (k == 51));
         end
         if (exp_v) begin
            checks++;
            if (rk_idx !== 4'(n) || rk !== a1_rk[n]) begin
               failures++;
               $display("FAIL ign_rk c=%0d got idx=%0d rk=%h exp idx=%0d rk=%h", k, rk_idx, rk, n, a1_rk[n]);
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ign_busy_end got=%b exp=0", busy);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      key   = a1_key;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 23; k++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, rk_valid, rk_idx, rk, done} !== '0) begin
         failures++;
         $display("FAIL arst_immediate got busy=%b v=%b idx=%0d rk=%h done=%b exp all 0", busy, rk_valid, rk_idx, rk, done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, rk_valid, done} !== 3'b000) begin
         failures++;
         $display("FAIL arst_no_resume got busy=%b v=%b done=%b exp 0 0 0", busy, rk_valid, done);
      end
      @(negedge clk);
      key   = a1_key;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
         #1;
         if (k == 1) begin
            checks++;
            if (rk_valid !== 1'b1 || rk !== a1_rk[0]) begin
               failures++;
               $display("FAIL arst_rk0 got v=%b rk=%h exp v=1 rk=%h", rk_valid, rk, a1_rk[0]);
            end
         end
         if (k == 5) begin
            checks++;
            if (rk_valid !== 1'b0) begin
               failures++;
               $display("FAIL arst_early got v=%b exp=0", rk_valid);
            end
         end
         if (k == 6) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'd1 || rk !== a1_rk[1]) begin
               failures++;
               $display("FAIL arst_rk1 got v=%b idx=%0d rk=%h exp v=1 idx=1 rk=%h", rk_valid, rk_idx, rk, a1_rk[1]);
            end
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      int base;
      logic exp_v;
      logic exp_busy;
      int n;
      @(negedge clk);
      key   = a1_key;
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 119; c++) begin
         @(posedge clk);
         #1;
         base     = (c >= 105) ? 105 : ((c >= 53) ? 53 : 1);
         exp_v    = ((c - base) % 5 == 0);
         n        = (c - base) / 5;
         exp_busy = !(c == 52 || c == 104);
         checks++;
         if (rk_valid !== exp_v) begin
            failures++;
            $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, rk_valid, exp_v);
         end
         checks++;
         if (done !== (c == 51 || c == 103)) begin
            failures++;
            $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, (c == 51 || c == 103));
         end
         checks++;
         if (busy !== exp_busy) begin
            failures++;
            $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy, exp_busy);
         end
         if (exp_v) begin
            checks++;
            if (rk_idx !== 4'(n) || rk !== a1_rk[n]) begin
               failures++;
               $display("FAIL b2b_rk c=%0d got idx=%0d rk=%h exp idx=%0d rk=%h", c, rk_idx, rk, n, a1_rk[n]);
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      a1_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      zero_rk1  = 128'h62636363626363636263636362636363;
      zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

      test_reset();
      test_fips_a1();
      test_zero_key();
      test_ignore_start();
      test_async_reset();
      test_back_to_back();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
